// File: rtl/btn_mode_ctrl.sv
// Five-button mode controller: synchronizes and debounces the push buttons,
// turns each accepted press into a one-cycle strobe, and selects/toggles an operation mode.
module btn_mode_ctrl #(
  parameter int BITS            = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  input  logic [BITS-1:0] sw,
  output logic [4:0]      btn_pulse,
  output logic [2:0]      mode,
  output logic            mode_change,
  output logic [BITS-1:0] sw_hold
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_MULT = 3'd1;
  localparam logic [2:0] MODE_LO   = 3'd2;
  localparam logic [2:0] MODE_NO   = 3'd3;
  localparam logic [2:0] MODE_ADD  = 3'd4;
  localparam logic [2:0] MODE_SUB  = 3'd5;

  logic [4:0]      btn_sync_q [SYNC_STAGES];
  logic [4:0]      btn_sync_d [SYNC_STAGES];
  logic [BITS-1:0] sw_sync_q  [SYNC_STAGES];
  logic [BITS-1:0] sw_sync_d  [SYNC_STAGES];

  logic [4:0]       stable_q, stable_d;
  logic [4:0]       stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [4:0]       btn_pulse_q, btn_pulse_d;

  logic [2:0]      mode_q, mode_d;
  logic            mode_change_q, mode_change_d;
  logic [BITS-1:0] sw_hold_q, sw_hold_d;
  logic [2:0]      win_code;
  logic [4:0]      btn_synced;

  // Bit order {R,L,D,U,C} is kept from the synchronizer through to btn_pulse.
  always_comb begin
    btn_sync_d[0] = {BTNR, BTNL, BTND, BTNU, BTNC};
    sw_sync_d[0]  = sw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      btn_sync_d[i] = btn_sync_q[i-1];
      sw_sync_d[i]  = sw_sync_q[i-1];
    end
  end

  assign btn_synced = btn_sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (btn_synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = btn_synced[i];
        else                     cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
    btn_pulse_d = stable_q & ~stable_prev_q;
  end

  // Lowest bit index wins: C > U > D > L > R.
  always_comb begin
    win_code = MODE_NONE;
    if      (btn_pulse_q[0]) win_code = MODE_MULT;
    else if (btn_pulse_q[1]) win_code = MODE_LO;
    else if (btn_pulse_q[2]) win_code = MODE_NO;
    else if (btn_pulse_q[3]) win_code = MODE_ADD;
    else if (btn_pulse_q[4]) win_code = MODE_SUB;
  end

  always_comb begin
    mode_d        = mode_q;
    sw_hold_d     = sw_hold_q;
    mode_change_d = 1'b0;
    if (|btn_pulse_q) begin
      mode_change_d = 1'b1;
      if (win_code == mode_q) begin
        mode_d = MODE_NONE;
      end else begin
        mode_d    = win_code;
        sw_hold_d = sw_sync_q[SYNC_STAGES-1];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: synchronizer and counter arrays are ordinary flops, so they are reset element by element.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= '0;
        sw_sync_q[i]  <= '0;
      end
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      btn_pulse_q   <= '0;
      mode_q        <= MODE_NONE;
      mode_change_q <= 1'b0;
      sw_hold_q     <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= btn_sync_d[i];
        sw_sync_q[i]  <= sw_sync_d[i];
      end
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      btn_pulse_q   <= btn_pulse_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      sw_hold_q     <= sw_hold_d;
    end
  end

  assign btn_pulse   = btn_pulse_q;
  assign mode        = mode_q;
  assign mode_change = mode_change_q;
  assign sw_hold     = sw_hold_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a timestamp-based model.
module tb_btn_mode_ctrl;

  localparam int BITS = 16;
  localparam int D    = 4;
  localparam int S    = 2;
  localparam int N    = 8192;

  logic            clk = 1'b0;
  logic            rst;
  logic            BTNC, BTNU, BTND, BTNL, BTNR;
  logic [BITS-1:0] sw;
  logic [4:0]      btn_pulse;
  logic [2:0]      mode;
  logic            mode_change;
  logic [BITS-1:0] sw_hold;

  int tests = 0;
  int fails = 0;

  btn_mode_ctrl #(.BITS(BITS), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .sw(sw), .btn_pulse(btn_pulse), .mode(mode),
    .mode_change(mode_change), .sw_hold(sw_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-edge histories indexed by edge number since reset.
  // A synced level is accepted once it has been constant and different from
  // the accepted level for D edges, measured from the edge it first appeared.
  logic [4:0]      raw_h  [N];
  logic [BITS-1:0] sw_h   [N];
  logic [4:0]      stab_h [N];
  logic [4:0]      pul_h  [N];
  logic [2:0]      mode_h [N];
  logic [BITS-1:0] hold_h [N];
  int              k;
  int              chg [5];

  function automatic logic [4:0] raw_at(int j);
    return (j < 1) ? 5'b0 : raw_h[j];
  endfunction

  function automatic logic [BITS-1:0] sw_at(int j);
    return (j < 1) ? '0 : sw_h[j];
  endfunction

  task automatic model_clear();
    k = 0;
    for (int i = 0; i < 5; i++) chg[i] = 0;
    stab_h[0] = '0;
    pul_h[0]  = '0;
    mode_h[0] = '0;
    hold_h[0] = '0;
  endtask

  task automatic model_step();
    logic [4:0] s_now, s_prev, stab, p;
    int code;
    k = k + 1;
    raw_h[k] = {BTNR, BTNL, BTND, BTNU, BTNC};
    sw_h[k]  = sw;
    s_now  = raw_at(k - S);
    s_prev = raw_at(k - S - 1);
    stab   = stab_h[k-1];
    for (int i = 0; i < 5; i++) begin
      if (s_now[i] != s_prev[i]) chg[i] = k;
      if (s_now[i] != stab[i] && (k - chg[i] + 1) >= D) stab[i] = s_now[i];
    end
    stab_h[k] = stab;
    pul_h[k]  = stab_h[k-1] & ~((k >= 2) ? stab_h[k-2] : 5'b0);
    mode_h[k] = mode_h[k-1];
    hold_h[k] = hold_h[k-1];
    p = pul_h[k-1];
    if (p != 0) begin
      code = 0;
      for (int i = 4; i >= 0; i--) if (p[i]) code = i + 1;
      if (code == int'(mode_h[k-1])) begin
        mode_h[k] = 3'd0;
      end else begin
        mode_h[k] = 3'(code);
        hold_h[k] = sw_at(k - S);
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("model_pulse", 32'(btn_pulse), 32'(pul_h[k]));
      check("model_mode", 32'(mode), 32'(mode_h[k]));
      check("model_mode_change", 32'(mode_change), 32'((k >= 1) && (pul_h[k-1] != 0)));
      check("model_sw_hold", 32'(sw_hold), 32'(hold_h[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    {BTNR, BTNL, BTND, BTNU, BTNC} = 5'b0;
    repeat (12) tick();
  endtask

  int pcnt, mccnt;
  logic mode_bad;
  logic [4:0] lvl;
  int dur [5];

  initial begin
    rst = 1'b1;
    {BTNR, BTNL, BTND, BTNU, BTNC} = 5'b0;
    sw = '0;
    repeat (3) tick();
    check("reset_pulse", 32'(btn_pulse), 32'h0);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_sw_hold", 32'(sw_hold), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Clean press of L.
    BTNL = 1'b1; sw = 16'h00A5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("clean_pulse", 32'(btn_pulse), (e == 7) ? 32'h08 : 32'h0);
      if (e == 8) begin
        check("clean_mode", 32'(mode), 32'd4);
        check("clean_sw_hold", 32'(sw_hold), 32'h00A5);
        check("clean_mode_change", 32'(mode_change), 32'h1);
      end
    end
    release_all();

    // Bounce on U: two 3-cycle glitches, then a steady press.
    pcnt = 0;
    for (int g = 0; g < 2; g++) begin
      BTNU = 1'b1;
      repeat (3) begin tick(); if (btn_pulse[1]) pcnt++; end
      BTNU = 1'b0;
      repeat (3) begin tick(); if (btn_pulse[1]) pcnt++; end
    end
    BTNU = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_pulse[1]) pcnt++;
      check("bounce_pulse", 32'(btn_pulse), (e == 7) ? 32'h02 : 32'h0);
      if (e == 8) check("bounce_mode", 32'(mode), 32'd2);
    end
    check("bounce_pulse_count", 32'(pcnt), 32'd1);
    release_all();

    // Simultaneous C and R.
    BTNC = 1'b1; BTNR = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check("simul_pulse", 32'(btn_pulse), 32'h11);
      if (e == 8) check("simul_mode", 32'(mode), 32'd1);
    end
    release_all();

    // Toggle D off.
    sw = 16'h1234; BTND = 1'b1;
    repeat (8) tick();
    check("toggle_setup_mode", 32'(mode), 32'd3);
    check("toggle_setup_hold", 32'(sw_hold), 32'h1234);
    release_all();
    sw = 16'h5555; BTND = 1'b1;
    mccnt = 0;
    repeat (12) begin tick(); if (mode_change) mccnt++; end
    check("toggle_mode", 32'(mode), 32'd0);
    check("toggle_sw_hold", 32'(sw_hold), 32'h1234);
    check("toggle_mode_change_count", 32'(mccnt), 32'd1);
    release_all();

    // Reset mid-debounce while R is held.
    sw = 16'h0BEE; BTNL = 1'b1;
    repeat (10) tick();
    check("rstmid_setup_mode", 32'(mode), 32'd4);
    release_all();
    BTNR = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rstmid_pulse", 32'(btn_pulse), 32'h0);
    check("rstmid_mode", 32'(mode), 32'h0);
    check("rstmid_mode_change", 32'(mode_change), 32'h0);
    check("rstmid_sw_hold", 32'(sw_hold), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("rstmid_after_pulse", 32'(btn_pulse), (e == 7) ? 32'h10 : 32'h0);
      if (e == 8) check("rstmid_after_mode", 32'(mode), 32'd5);
    end
    release_all();

    // C held for 100 cycles with sw wandering.
    sw = 16'h0C0C; BTNC = 1'b1;
    pcnt = 0; mccnt = 0; mode_bad = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (btn_pulse != 0) pcnt++;
      if (mode_change) mccnt++;
      if (e >= 8 && mode != 3'd1) mode_bad = 1'b1;
      if (e >= 10) sw = 16'($urandom);
    end
    check("held_pulse_count", 32'(pcnt), 32'd1);
    check("held_mode_change_count", 32'(mccnt), 32'd1);
    check("held_mode_stuck", 32'(mode_bad), 32'h0);
    check("held_sw_hold", 32'(sw_hold), 32'h0C0C);
    release_all();

    // Randomized phase; level durations straddle the debounce threshold.
    lvl = '0;
    for (int i = 0; i < 5; i++) dur[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = int'($urandom_range(1, 10));
        end else begin
          dur[i]--;
        end
      end
      {BTNR, BTNL, BTND, BTNU, BTNC} = lvl;
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      rst = (c >= 1500 && c < 1503);
      tick();
    end
    rst = 1'b0;
    release_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
